// File: rtl/sem_command_queue.sv
// sem_command_queue: FIFO-buffered issuer for the SEM controller command port.
// Packs queued requests, strobes them to an idle controller, times out handshakes.
module sem_command_queue #(
  parameter int DEPTH       = 4,
  parameter int PAD_W       = 10,
  parameter int LFA_W       = 18,
  parameter int WORD_W      = 7,
  parameter int BIT_W       = 5,
  parameter int ACK_CYCLES  = 16,
  parameter int DONE_CYCLES = 65536,
  localparam int CODE_W     = 4 + PAD_W + LFA_W + WORD_W + BIT_W,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [LFA_W-1:0]  req_lfa,
  input  logic [WORD_W-1:0] req_word,
  input  logic [BIT_W-1:0]  req_bit,
  input  logic              sem_en,
  input  logic              command_busy,
  output logic [CODE_W-1:0] command_code,
  output logic              command_strobe,
  output logic              issue_done,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              ack_timeout,
  output logic              done_timeout,
  input  logic              err_clr
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENT_W   = 4 + LFA_W + WORD_W + BIT_W;
  localparam int CNT_MAX = (ACK_CYCLES > DONE_CYCLES) ? ACK_CYCLES : DONE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  state_t            r_state;
  state_t            w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [CODE_W-1:0] r_code;
  logic              r_strobe;
  logic              r_done;
  logic              r_ack_to;
  logic              r_done_to;
  logic              w_push;
  logic              w_issue;
  logic              w_fin;
  logic              w_ack_ev;
  logic              w_done_ev;
  logic [ENT_W-1:0]  w_head;
  logic [CODE_W-1:0] w_head_code;

  assign req_ready   = !rst && (r_level < LVL_W'(DEPTH));
  assign w_push      = req_valid && req_ready;
  assign w_head      = r_mem[r_rptr];
  // Opcode sits above the pad; LFA/word/bit are contiguous below it.
  assign w_head_code = {w_head[ENT_W-1 -: 4], {PAD_W{1'b0}},
                        w_head[ENT_W-5:0]};

  assign command_code   = r_code;
  assign command_strobe = r_strobe;
  assign issue_done     = r_done;
  assign fifo_level     = r_level;
  assign ack_timeout    = r_ack_to;
  assign done_timeout   = r_done_to;

  // FIFO storage write; contents need no reset, level/pointers gate use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {req_cmd, req_lfa, req_word, req_bit};
    end
  end

  // FIFO pointers and occupancy; pop happens only on the issue decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + PTR_W'(1);
      if (w_issue) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_issue})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Issue/handshake FSM next state, counter and event decode.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_issue    = 1'b0;
    w_fin      = 1'b0;
    w_ack_ev   = 1'b0;
    w_done_ev  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_level != '0 && sem_en && !command_busy) begin
          w_issue    = 1'b1;
          w_cnt_nx   = '0;
          w_state_nx = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (command_busy) begin
          w_cnt_nx   = '0;
          w_state_nx = S_WAIT_DONE;
        end else if (r_cnt == CNT_W'(ACK_CYCLES - 1)) begin
          w_ack_ev   = 1'b1;
          w_fin      = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!command_busy) begin
          w_fin      = 1'b1;
          w_state_nx = S_IDLE;
        end else if (r_cnt == CNT_W'(DONE_CYCLES - 1)) begin
          w_done_ev  = 1'b1;
          w_fin      = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM state and handshake counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Registered outputs; a new timeout wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_code    <= '0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
      r_ack_to  <= 1'b0;
      r_done_to <= 1'b0;
    end else begin
      if (w_issue) r_code <= w_head_code;
      r_strobe  <= w_issue;
      r_done    <= w_fin;
      r_ack_to  <= (r_ack_to && !err_clr) || w_ack_ev;
      r_done_to <= (r_done_to && !err_clr) || w_done_ev;
    end
  end

endmodule

// File: tb/tb_sem_command_queue.sv
// tb_sem_command_queue: directed scenarios for sem_command_queue.
// Drives and samples on the falling edge, away from the active edge.
module tb_sem_command_queue;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [17:0] req_lfa;
  logic [6:0]  req_word;
  logic [4:0]  req_bit;
  logic        sem_en;
  logic        command_busy;
  logic [43:0] command_code;
  logic        command_strobe;
  logic        issue_done;
  logic [2:0]  fifo_level;
  logic        ack_timeout;
  logic        done_timeout;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  sem_command_queue #(
    .DONE_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd(req_cmd),
    .req_lfa(req_lfa),
    .req_word(req_word),
    .req_bit(req_bit),
    .sem_en(sem_en),
    .command_busy(command_busy),
    .command_code(command_code),
    .command_strobe(command_strobe),
    .issue_done(issue_done),
    .fifo_level(fifo_level),
    .ack_timeout(ack_timeout),
    .done_timeout(done_timeout),
    .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [43:0] pack(input logic [3:0] c,
                                       input logic [17:0] l,
                                       input logic [6:0] w,
                                       input logic [4:0] b);
    return {c, 10'd0, l, w, b};
  endfunction

  task automatic drive(input logic [3:0] c, input logic [17:0] l,
                       input logic [6:0] w, input logic [4:0] b);
    req_cmd  = c;
    req_lfa  = l;
    req_word = w;
    req_bit  = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    sem_en = 1'b0;
    command_busy = 1'b0;
    err_clr = 1'b0;
    drive(4'h0, 18'h0, 7'h0, 5'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got %b exp 0", req_ready);
    end
    checks++;
    if (command_strobe !== 1'b0 || issue_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulses got %b%b exp 00", command_strobe, issue_done);
    end
    checks++;
    if (command_code !== 44'h0) begin
      errors++; $display("FAIL rst_code got %h exp 0", command_code);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL rst_level got %0d exp 0", fifo_level);
    end
    checks++;
    if (ack_timeout !== 1'b0 || done_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got %b%b exp 00", ack_timeout, done_timeout);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_single();
    sem_en = 1'b1;
    command_busy = 1'b0;
    drive(4'hC, 18'h00123, 7'd5, 5'd3);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (command_strobe !== 1'b0 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL single_push got strobe=%b lvl=%0d exp 0/1",
               command_strobe, fifo_level);
    end
    @(negedge clk);
    checks++;
    if (command_strobe !== 1'b1) begin
      errors++; $display("FAIL single_strobe got %b exp 1", command_strobe);
    end
    checks++;
    if (command_code !== 44'hC00001230A3) begin
      errors++;
      $display("FAIL single_code got %h exp c00001230a3", command_code);
    end
    command_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (command_strobe !== 1'b0 || issue_done !== 1'b0) begin
        errors++;
        $display("FAIL single_busy[%0d] got strobe=%b done=%b exp 0/0",
                 i, command_strobe, issue_done);
      end
    end
    command_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (issue_done !== 1'b1) begin
      errors++; $display("FAIL single_done got %b exp 1", issue_done);
    end
    @(negedge clk);
    checks++;
    if (issue_done !== 1'b0 || command_code !== 44'hC00001230A3) begin
      errors++;
      $display("FAIL single_hold got done=%b code=%h exp 0/c00001230a3",
               issue_done, command_code);
    end
  endtask

  task automatic test_fill();
    logic [43:0] exp_q [5];
    logic        got;
    logic        pend;
    logic        pushed5;
    sem_en = 1'b0;
    command_busy = 1'b0;
    pushed5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q[i] = pack(4'(i + 1), 18'(i * 273 + 7), 7'(i + 2), 5'(i * 3));
    end
    for (int i = 0; i < 4; i++) begin
      drive(4'(i + 1), 18'(i * 273 + 7), 7'(i + 2), 5'(i * 3));
      req_valid = 1'b1;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready[%0d] got %b exp 1", i, req_ready);
      end
      @(negedge clk);
    end
    drive(4'd5, 18'(4 * 273 + 7), 7'd6, 5'd12);
    checks++;
    if (req_ready !== 1'b0 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL fill_full got ready=%b lvl=%0d exp 0/4",
               req_ready, fifo_level);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || fifo_level !== 3'd4 || command_strobe !== 1'b0) begin
      errors++;
      $display("FAIL fill_hold got ready=%b lvl=%0d stb=%b exp 0/4/0",
               req_ready, fifo_level, command_strobe);
    end
    sem_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        pend = req_valid && req_ready;
        @(negedge clk);
        if (pend) begin
          req_valid = 1'b0;
          pushed5 = 1'b1;
        end
        if (command_strobe) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL fill_strobe[%0d] got none exp strobe", k);
      end else begin
        checks++;
        if (command_code !== exp_q[k]) begin
          errors++;
          $display("FAIL fill_order[%0d] got %h exp %h", k, command_code,
                   exp_q[k]);
        end
      end
      command_busy = 1'b1;
      for (int c = 0; c < 3; c++) begin
        pend = req_valid && req_ready;
        @(negedge clk);
        if (pend) begin
          req_valid = 1'b0;
          pushed5 = 1'b1;
        end
        checks++;
        if (command_strobe !== 1'b0) begin
          errors++;
          $display("FAIL fill_busy_gate[%0d] got %b exp 0", k, command_strobe);
        end
      end
      command_busy = 1'b0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pushed5 !== 1'b1 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL fill_drain got pushed5=%b lvl=%0d exp 1/0",
               pushed5, fifo_level);
    end
  endtask

  task automatic test_ack_timeout();
    sem_en = 1'b1;
    command_busy = 1'b0;
    drive(4'hA, 18'h2AAAA, 7'h11, 5'h0A);
    req_valid = 1'b1;
    @(negedge clk);
    drive(4'hB, 18'h15555, 7'h22, 5'h15);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (command_strobe !== 1'b1 ||
        command_code !== pack(4'hA, 18'h2AAAA, 7'h11, 5'h0A)) begin
      errors++;
      $display("FAIL ack_first got stb=%b code=%h", command_strobe,
               command_code);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16) begin
        checks++;
        if (ack_timeout !== 1'b0 || command_strobe !== 1'b0 ||
            issue_done !== 1'b0) begin
          errors++;
          $display("FAIL ack_early[%0d] got to=%b stb=%b done=%b exp 0/0/0",
                   k, ack_timeout, command_strobe, issue_done);
        end
      end else begin
        checks++;
        if (ack_timeout !== 1'b1 || issue_done !== 1'b1) begin
          errors++;
          $display("FAIL ack_timeout got to=%b done=%b exp 1/1",
                   ack_timeout, issue_done);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (command_strobe !== 1'b1 ||
        command_code !== pack(4'hB, 18'h15555, 7'h22, 5'h15)) begin
      errors++;
      $display("FAIL ack_next got stb=%b code=%h", command_strobe,
               command_code);
    end
    command_busy = 1'b1;
    repeat (2) @(negedge clk);
    command_busy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ack_timeout !== 1'b1) begin
      errors++; $display("FAIL ack_sticky got %b exp 1", ack_timeout);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (ack_timeout !== 1'b0) begin
      errors++; $display("FAIL ack_clr got %b exp 0", ack_timeout);
    end
  endtask

  task automatic test_done_timeout();
    sem_en = 1'b1;
    command_busy = 1'b0;
    drive(4'h3, 18'h00042, 7'h01, 5'h01);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (command_strobe !== 1'b1) begin
      errors++; $display("FAIL done_strobe got %b exp 1", command_strobe);
    end
    command_busy = 1'b1;
    drive(4'h7, 18'h00077, 7'h07, 5'h07);
    req_valid = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k < 33) begin
        checks++;
        if (done_timeout !== 1'b0 || command_strobe !== 1'b0) begin
          errors++;
          $display("FAIL done_early[%0d] got to=%b stb=%b exp 0/0",
                   k, done_timeout, command_strobe);
        end
      end else begin
        checks++;
        if (done_timeout !== 1'b1 || issue_done !== 1'b1) begin
          errors++;
          $display("FAIL done_timeout got to=%b done=%b exp 1/1",
                   done_timeout, issue_done);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (command_strobe !== 1'b0 || fifo_level !== 3'd1) begin
        errors++;
        $display("FAIL done_gate[%0d] got stb=%b lvl=%0d exp 0/1",
                 k, command_strobe, fifo_level);
      end
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (done_timeout !== 1'b0) begin
      errors++; $display("FAIL done_clr got %b exp 0", done_timeout);
    end
    command_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (command_strobe !== 1'b1 ||
        command_code !== pack(4'h7, 18'h00077, 7'h07, 5'h07)) begin
      errors++;
      $display("FAIL done_resume got stb=%b code=%h", command_strobe,
               command_code);
    end
    command_busy = 1'b1;
    repeat (2) @(negedge clk);
    command_busy = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy_gating();
    sem_en = 1'b1;
    command_busy = 1'b1;
    drive(4'h9, 18'h3FFFF, 7'h7F, 5'h1F);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (command_strobe !== 1'b0 || fifo_level !== 3'd1) begin
        errors++;
        $display("FAIL gate_hold[%0d] got stb=%b lvl=%0d exp 0/1",
                 k, command_strobe, fifo_level);
      end
    end
    command_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (command_strobe !== 1'b1 || command_code !== 44'h9003FFFFFFF) begin
      errors++;
      $display("FAIL gate_release got stb=%b code=%h exp 1/9003fffffff",
               command_strobe, command_code);
    end
    command_busy = 1'b1;
    repeat (2) @(negedge clk);
    command_busy = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    sem_en = 1'b1;
    command_busy = 1'b0;
    drive(4'h1, 18'h00001, 7'h01, 5'h01);
    req_valid = 1'b1;
    @(negedge clk);
    drive(4'h2, 18'h00002, 7'h02, 5'h02);
    @(negedge clk);
    command_busy = 1'b1;
    drive(4'h4, 18'h00004, 7'h04, 5'h04);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd2) begin
      errors++; $display("FAIL mid_level got %0d exp 2", fifo_level);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || command_code !== 44'h0 ||
        command_strobe !== 1'b0 || issue_done !== 1'b0 ||
        req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got lvl=%0d code=%h stb=%b done=%b rdy=%b",
               fifo_level, command_code, command_strobe, issue_done,
               req_ready);
    end
    rst = 1'b0;
    command_busy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (command_strobe !== 1'b0 || issue_done !== 1'b0 ||
          fifo_level !== 3'd0) begin
        errors++;
        $display("FAIL mid_after[%0d] got stb=%b done=%b lvl=%0d exp 0/0/0",
                 k, command_strobe, issue_done, fifo_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_ack_timeout();
    test_done_timeout();
    test_busy_gating();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
